// File: rtl/saes_pkg.sv
// Shared definitions for the S-AES decryption datapath: FSM encodings,
// S-box tables, round constants and GF(2^4) helpers.
package saes_pkg;

   // FSM state encodings, listed in execution order.
   localparam logic [3:0] ST_IDLE       = 4'd0;
   localparam logic [3:0] ST_KEYX       = 4'd1;
   localparam logic [3:0] ST_AK2        = 4'd2;
   localparam logic [3:0] ST_ISR1       = 4'd3;
   localparam logic [3:0] ST_INS1_ISSUE = 4'd4;
   localparam logic [3:0] ST_INS1_WAIT  = 4'd5;
   localparam logic [3:0] ST_AK1        = 4'd6;
   localparam logic [3:0] ST_IMC        = 4'd7;
   localparam logic [3:0] ST_ISR2       = 4'd8;
   localparam logic [3:0] ST_INS2_ISSUE = 4'd9;
   localparam logic [3:0] ST_INS2_WAIT  = 4'd10;
   localparam logic [3:0] ST_AK0        = 4'd11;
   localparam logic [3:0] ST_DONE       = 4'd12;

   // Key schedule round constants.
   localparam logic [7:0] RCON1 = 8'h80;
   localparam logic [7:0] RCON2 = 8'h30;

   // S-box tables packed with entry 0 in the top nibble.
   localparam logic [63:0] SBOX_TABLE     = 64'h94ABD1856203CEF7;
   localparam logic [63:0] INV_SBOX_TABLE = 64'hA59B178F6023C4DE;

   function automatic logic [3:0] sbox(input logic [3:0] n);
      return SBOX_TABLE[6'd60 - {n, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] n);
      return INV_SBOX_TABLE[6'd60 - {n, 2'b00} +: 4];
   endfunction

   // Multiply by x in GF(2^4) modulo x^4+x+1 (x^4 folds back to x+1).
   function automatic logic [3:0] gf_mul2(input logic [3:0] a);
      return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
   endfunction

   // Multiply by 9 = x^3 + 1.
   function automatic logic [3:0] gf_mul9(input logic [3:0] a);
      logic [3:0] m8;
      m8 = gf_mul2(gf_mul2(gf_mul2(a)));
      return m8 ^ a;
   endfunction

endpackage

// File: rtl/saes_inv_sbox.sv
// Four parallel inverse S-box nibble lookups with a registered output.
// One cycle of latency; the data path carries no reset.
module saes_inv_sbox
   import saes_pkg::*;
(
   input  logic        clk,
   input  logic [15:0] din,
   output logic [15:0] dout
);

   // Register the substituted word every cycle.
   always_ff @(posedge clk) begin
      dout <= {inv_sbox(din[15:12]), inv_sbox(din[11:8]),
               inv_sbox(din[7:4]),   inv_sbox(din[3:0])};
   end

endmodule

// File: rtl/saes_decrypt_core.sv
// Sequential S-AES decryption core. One inverse transform per cycle under
// a start/done handshake; inverse substitution goes through a registered
// lookup and waits SBOX_WAIT cycles before latching its result.
// Handshake: start is sampled only in IDLE; done pulses for one cycle with
// pt_out valid in that same cycle; busy covers KEYX through DONE.
module saes_decrypt_core
   import saes_pkg::*;
#(
   parameter int SBOX_WAIT = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] ct_in,
   input  logic [15:0] key_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] pt_out
);

   localparam int CW = (SBOX_WAIT > 1) ? $clog2(SBOX_WAIT) : 1;
   localparam logic [CW-1:0] WAIT_LAST = CW'(SBOX_WAIT - 1);

   logic [3:0]    state_q;
   logic [15:0]   data_q;
   logic [15:0]   key_q;
   logic [15:0]   k1_q;
   logic [15:0]   k2_q;
   logic [CW-1:0] wait_cnt;
   logic [15:0]   sbox_out;

   logic [7:0]    w0, w1, w2, w3, w4, w5;
   logic [15:0]   isr_data;
   logic [15:0]   imc_data;

   function automatic logic [7:0] sub_nib(input logic [7:0] w);
      return {sbox(w[7:4]), sbox(w[3:0])};
   endfunction

   function automatic logic [7:0] rot_nib(input logic [7:0] w);
      return {w[3:0], w[7:4]};
   endfunction

   // Key expansion from the captured master key; k0 is the key itself.
   always_comb begin
      w0 = key_q[15:8];
      w1 = key_q[7:0];
      w2 = w0 ^ RCON1 ^ sub_nib(rot_nib(w1));
      w3 = w2 ^ w1;
      w4 = w2 ^ RCON2 ^ sub_nib(rot_nib(w3));
      w5 = w4 ^ w3;
   end

   // Inverse ShiftRows swaps s10 and s11; inverse MixColumns per column.
   always_comb begin
      isr_data = {data_q[15:12], data_q[3:0], data_q[7:4], data_q[11:8]};
      imc_data = {gf_mul9(data_q[15:12]) ^ gf_mul2(data_q[11:8]),
                  gf_mul2(data_q[15:12]) ^ gf_mul9(data_q[11:8]),
                  gf_mul9(data_q[7:4])   ^ gf_mul2(data_q[3:0]),
                  gf_mul2(data_q[7:4])   ^ gf_mul9(data_q[3:0])};
   end

   saes_inv_sbox u_inv_sbox (
      .clk  (clk),
      .din  (data_q),
      .dout (sbox_out)
   );

   // Main FSM: sequences the inverse rounds and owns all output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         data_q   <= '0;
         key_q    <= '0;
         k1_q     <= '0;
         k2_q     <= '0;
         wait_cnt <= '0;
         pt_out   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  data_q  <= ct_in;
                  key_q   <= key_in;
                  busy    <= 1'b1;
                  state_q <= ST_KEYX;
               end
            end
            ST_KEYX: begin
               k1_q    <= {w2, w3};
               k2_q    <= {w4, w5};
               state_q <= ST_AK2;
            end
            ST_AK2: begin
               data_q  <= data_q ^ k2_q;
               state_q <= ST_ISR1;
            end
            ST_ISR1: begin
               data_q  <= isr_data;
               state_q <= ST_INS1_ISSUE;
            end
            ST_INS1_ISSUE: begin
               // The lookup registers data_q on this edge.
               wait_cnt <= '0;
               state_q  <= ST_INS1_WAIT;
            end
            ST_INS1_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  data_q  <= sbox_out;
                  state_q <= ST_AK1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_AK1: begin
               data_q  <= data_q ^ k1_q;
               state_q <= ST_IMC;
            end
            ST_IMC: begin
               data_q  <= imc_data;
               state_q <= ST_ISR2;
            end
            ST_ISR2: begin
               data_q  <= isr_data;
               state_q <= ST_INS2_ISSUE;
            end
            ST_INS2_ISSUE: begin
               wait_cnt <= '0;
               state_q  <= ST_INS2_WAIT;
            end
            ST_INS2_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  data_q  <= sbox_out;
                  state_q <= ST_AK0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_AK0: begin
               // pt_out and done rise together on entry to DONE.
               data_q  <= data_q ^ key_q;
               pt_out  <= data_q ^ key_q;
               done    <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_saes_decrypt_core.sv
// Bench for saes_decrypt_core: directed vectors on a default instance and
// an encrypt-then-decrypt loopback stream on an SBOX_WAIT=3 instance.
module tb_saes_decrypt_core;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start, start3;
   logic [15:0] ct_in, key_in, ct3, key3;
   logic        busy, done, busy3, done3;
   logic [15:0] pt_out, pt3;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   saes_decrypt_core dut (
      .clk(clk), .rst(rst), .start(start), .ct_in(ct_in), .key_in(key_in),
      .busy(busy), .done(done), .pt_out(pt_out)
   );

   saes_decrypt_core #(.SBOX_WAIT(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .ct_in(ct3), .key_in(key3),
      .busy(busy3), .done(done3), .pt_out(pt3)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int failures = 0;
   logic [15:0] exp_q[$];
   int          acc_q[$];
   logic [15:0] exp3_q[$];
   int          acc3_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   // ---------------- reference encryption model ----------------
   function automatic logic [3:0] m_sbox(input logic [3:0] n);
      logic [63:0] t;
      t = 64'h94ABD1856203CEF7;
      return t[(15 - int'(n)) * 4 +: 4];
   endfunction

   function automatic logic [3:0] m_gfmul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] p, x;
      p = 4'h0;
      x = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p = p ^ x;
         x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [7:0] m_sub8(input logic [7:0] w);
      return {m_sbox(w[7:4]), m_sbox(w[3:0])};
   endfunction

   function automatic logic [15:0] m_sub16(input logic [15:0] s);
      return {m_sub8(s[15:8]), m_sub8(s[7:0])};
   endfunction

   function automatic logic [15:0] m_sr(input logic [15:0] s);
      return {s[15:12], s[3:0], s[7:4], s[11:8]};
   endfunction

   function automatic logic [15:0] m_mc(input logic [15:0] s);
      return {s[15:12] ^ m_gfmul(4'h4, s[11:8]), m_gfmul(4'h4, s[15:12]) ^ s[11:8],
              s[7:4] ^ m_gfmul(4'h4, s[3:0]),    m_gfmul(4'h4, s[7:4]) ^ s[3:0]};
   endfunction

   function automatic logic [15:0] m_encrypt(input logic [15:0] p, input logic [15:0] k);
      logic [7:0] w0, w1, w2, w3, w4, w5;
      logic [15:0] s;
      w0 = k[15:8];
      w1 = k[7:0];
      w2 = w0 ^ 8'h80 ^ m_sub8({w1[3:0], w1[7:4]});
      w3 = w2 ^ w1;
      w4 = w2 ^ 8'h30 ^ m_sub8({w3[3:0], w3[7:4]});
      w5 = w4 ^ w3;
      s = p ^ k;
      s = m_mc(m_sr(m_sub16(s))) ^ {w2, w3};
      s = m_sr(m_sub16(s)) ^ {w4, w5};
      return s;
   endfunction

   // ---------------- monitors ----------------
   logic [15:0] mon_e, mon3_e;
   int          mon_a, mon3_a;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done cyc=%0d actual=1 required=0", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            mon_a = acc_q.pop_front();
            check("pt_out", pt_out, mon_e);
            check("done_latency", cyc - mon_a + 1, 14);
            check("busy_at_done", busy, 1);
         end
      end
   end

   always @(negedge clk) begin
      if (done3 === 1'b1) begin
         if (exp3_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done3 cyc=%0d actual=1 required=0", cyc);
         end else begin
            mon3_e = exp3_q.pop_front();
            mon3_a = acc3_q.pop_front();
            check("pt3_loopback", pt3, mon3_e);
            check("done3_latency", cyc - mon3_a + 1, 16);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_op(input logic [15:0] ct, input logic [15:0] key,
                           input bit push, input logic [15:0] exp_pt);
      @(posedge clk); #1;
      start  = 1'b1;
      ct_in  = ct;
      key_in = key;
      @(posedge clk); #1;
      start = 1'b0;
      if (push) begin
         exp_q.push_back(exp_pt);
         acc_q.push_back(cyc);
      end
   endtask

   task automatic wait_done(input int budget, input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (done !== 1'b1 && n < budget) begin
         n++;
         @(negedge clk);
      end
      check(name, done, 1);
   endtask

   // ---------------- stimulus ----------------
   logic [15:0] pt_arr[256];
   logic [15:0] ct_arr[256];
   int          acc3;

   initial begin
      rst = 1'b1; start = 1'b0; start3 = 1'b0;
      ct_in = '0; key_in = '0; ct3 = '0; key3 = '0;

      // Reset for two cycles, then idle with no change.
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pt_out", pt_out, 16'h0000);
      check("rst_pt3", pt3, 16'h0000);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_busy", busy, 0);
         check("idle_pt_out", pt_out, 16'h0000);
      end

      // Standard vector with busy tracked through the run.
      start_op(16'h0738, 16'hA73B, 1'b1, 16'h6F6B);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         check("run_busy", busy, 1);
         check("run_done_low", done, 0);
      end
      wait_done(4, "std_done_seen");
      @(negedge clk);
      check("after_busy", busy, 0);
      check("after_done", done, 0);
      check("after_pt_held", pt_out, 16'h6F6B);

      // Second vector; inputs scrambled right after accept.
      start_op(16'h24EC, 16'h4AF5, 1'b1, 16'hD728);
      ct_in  = 16'hFFFF;
      key_in = 16'hFFFF;
      wait_done(20, "vec2_done_seen");

      // Busy collision: start pulsed in cycle 3 and cycles 13-14 (DONE).
      start_op(16'h0738, 16'hA73B, 1'b1, 16'h6F6B);
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1; ct_in = 16'h1234; key_in = 16'h0000;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1; ct_in = 16'h5555;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("no_restart_busy", busy, 0);
      end

      // Reset in cycle 6 of an operation.
      start_op(16'h24EC, 16'h4AF5, 1'b0, 16'h0000);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_pt_out", pt_out, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("midrst_idle_busy", busy, 0);
      end
      start_op(16'h0738, 16'hA73B, 1'b1, 16'h6F6B);
      wait_done(20, "postrst_done_seen");

      // Loopback stream on the SBOX_WAIT=3 instance with start held high.
      for (int i = 0; i < 256; i++) begin
         pt_arr[i] = 16'($urandom_range(0, 65535));
         ct_arr[i] = m_encrypt(pt_arr[i], 16'h2D65);
      end
      @(posedge clk); #1;
      start3 = 1'b1;
      key3   = 16'h2D65;
      ct3    = ct_arr[0];
      @(posedge clk); #1;
      acc3 = cyc;
      for (int i = 0; i < 256; i++) begin
         if (i > 0) begin
            repeat (17) @(posedge clk);
            #1;
            acc3 = acc3 + 17;
         end
         exp3_q.push_back(pt_arr[i]);
         acc3_q.push_back(acc3);
         if (i < 255) ct3 = ct_arr[i + 1];
         else start3 = 1'b0;
      end
      for (int n = 0; n < 40 && exp3_q.size() > 0; n++) @(negedge clk);
      repeat (5) @(negedge clk);
      check("dut3_busy_end", busy3, 0);

      check("queue_drained", exp_q.size(), 0);
      check("queue3_drained", exp3_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound.
   initial begin
      #300000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
